// File: rtl/ez8_prog_loader.sv
// rtl/ez8_prog_loader.sv - framed byte-stream program loader for the ez8 instruction memory
module ez8_prog_loader #(
   parameter int ADDR_WIDTH = 12,
   parameter int WORD_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  reload,
   output logic [ADDR_WIDTH-1:0] instr_writeaddr,
   output logic [WORD_WIDTH-1:0] instr_writedata,
   output logic                  instr_write_en,
   output logic                  cpu_pause,
   output logic                  cpu_reset,
   output logic                  done,
   output logic                  error
);

   // Word counter is compared against a 12-bit frame length, so widen both sides
   // to whichever is larger plus one bit to hold "words written" without wrapping.
   localparam int CW = ((ADDR_WIDTH > 12) ? ADDR_WIDTH : 12) + 1;

   typedef enum logic [3:0] {
      S_LEN_HI,
      S_LEN_LO,
      S_DATA_HI,
      S_DATA_LO,
      S_WRITE,
      S_SUM,
      S_CPU_RST,
      S_RUN,
      S_ERROR
   } state_t;

   state_t                  state, state_n;
   logic [11:0]             len_q;
   logic [WORD_WIDTH-1:0]   data_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [7:0]              sum_q;
   logic                    xfer;
   logic                    last_word;
   logic [CW-1:0]           written;

   assign xfer      = in_valid && in_ready;
   assign written   = CW'(addr_q) + CW'(1);
   assign last_word = (written == CW'(len_q));

   // All handshake and CPU-control outputs are decoded straight from state.
   assign in_ready        = (state == S_LEN_HI) || (state == S_LEN_LO) || (state == S_DATA_HI) ||
                            (state == S_DATA_LO) || (state == S_SUM);
   assign instr_write_en  = (state == S_WRITE);
   assign cpu_pause       = !((state == S_CPU_RST) || (state == S_RUN));
   assign cpu_reset       = (state == S_CPU_RST);
   assign done            = (state == S_RUN);
   assign error           = (state == S_ERROR);
   assign instr_writeaddr = addr_q;
   assign instr_writedata = data_q;

   // State register plus the datapath registers captured on byte transfers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= S_LEN_HI;
         len_q  <= '0;
         data_q <= '0;
         addr_q <= '0;
         sum_q  <= '0;
      end else begin
         state <= state_n;
         case (state)
            S_LEN_HI: if (xfer) len_q[11:8] <= in_data[3:0];
            S_LEN_LO: if (xfer) len_q[7:0] <= in_data;
            S_DATA_HI: begin
               if (xfer) begin
                  data_q[WORD_WIDTH-1 -: 8] <= in_data;
                  sum_q                     <= sum_q + in_data;
               end
            end
            S_DATA_LO: begin
               if (xfer) begin
                  data_q[7:0] <= in_data;
                  sum_q       <= sum_q + in_data;
               end
            end
            // Address advances as the strobe drops so it is stable while the strobe is high.
            S_WRITE: addr_q <= addr_q + 1'b1;
            // Re-entering LEN_HI from a terminal state starts a clean frame.
            S_RUN, S_ERROR: begin
               if (reload) begin
                  addr_q <= '0;
                  sum_q  <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   // Next-state decode; byte states only move on an accepted transfer.
   always_comb begin
      state_n = state;
      case (state)
         S_LEN_HI: begin
            if (xfer) state_n = (in_data[7:4] != 4'd0) ? S_ERROR : S_LEN_LO;
         end
         S_LEN_LO: begin
            if (xfer) state_n = ({len_q[11:8], in_data} == 12'd0) ? S_SUM : S_DATA_HI;
         end
         S_DATA_HI: if (xfer) state_n = S_DATA_LO;
         S_DATA_LO: if (xfer) state_n = S_WRITE;
         S_WRITE:   state_n = last_word ? S_SUM : S_DATA_HI;
         S_SUM: begin
            if (xfer) state_n = (in_data == sum_q) ? S_CPU_RST : S_ERROR;
         end
         S_CPU_RST: state_n = S_RUN;
         S_RUN:     if (reload) state_n = S_LEN_HI;
         S_ERROR:   if (reload) state_n = S_LEN_HI;
         default:   state_n = S_LEN_HI;
      endcase
   end

endmodule

// File: tb/tb_ez8_prog_loader.sv
// tb/tb_ez8_prog_loader.sv - self-checking bench for ez8_prog_loader
module tb_ez8_prog_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        reload;
   logic [11:0] instr_writeaddr;
   logic [15:0] instr_writedata;
   logic        instr_write_en;
   logic        cpu_pause;
   logic        cpu_reset;
   logic        done;
   logic        error;

   ez8_prog_loader #(.ADDR_WIDTH(12), .WORD_WIDTH(16)) dut (
      .clk             (clk),
      .reset           (reset),
      .in_data         (in_data),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .reload          (reload),
      .instr_writeaddr (instr_writeaddr),
      .instr_writedata (instr_writedata),
      .instr_write_en  (instr_write_en),
      .cpu_pause       (cpu_pause),
      .cpu_reset       (cpu_reset),
      .done            (done),
      .error           (error)
   );

   // Free-running clock, 10 time-unit period.
   always #5 clk = ~clk;

   typedef struct {
      int off;
      int n;
      bit gaps;
      bit exp_done;
      bit exp_err;
      int exp_writes;
   } vec_t;

   int          checks = 0;
   int          failures = 0;
   int          rst_pulses = 0;
   int          strobes = 0;
   logic [27:0] sb[$];
   logic [27:0] e;
   logic [7:0]  stream[$];
   vec_t        vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Scoreboard monitor: every strobe pops one expected {addr,data}; count cpu_reset pulses.
   always @(negedge clk) begin
      if (!reset) begin
         if (instr_write_en) begin
            strobes++;
            chk("strobe_in_ready_low", {31'd0, in_ready}, 32'd0);
            if (sb.size() == 0) begin
               chk("unexpected_strobe", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("write_addr_data", {4'd0, instr_writeaddr, instr_writedata}, {4'd0, e});
            end
         end
         if (cpu_reset) begin
            rst_pulses++;
            chk("cpu_reset_pause_low", {31'd0, cpu_pause}, 32'd0);
         end
      end
   end

   // Present one byte, optionally after a random idle gap, and return #1 after it is accepted.
   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int t;
      if (gaps) begin
         in_valid = 1'b0;
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      @(negedge clk);
      in_data  = b;
      in_valid = 1'b1;
      t = 0;
      while (!in_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         chk("in_ready_timeout", 32'd0, 32'd1);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic pulse_reload();
      @(negedge clk);
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
   endtask

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      reload   = 1'b0;

      stream = '{8'h00, 8'h05, 8'h40, 8'h50, 8'h01, 8'h01, 8'h41, 8'h00, 8'h21, 8'h00, 8'h61, 8'h48, 8'h9D,
                 8'h00, 8'h05, 8'h40, 8'h50, 8'h01, 8'h01, 8'h41, 8'h00, 8'h21, 8'h00, 8'h61, 8'h48, 8'h9C,
                 8'h00, 8'h00, 8'h00,
                 8'h00, 8'h00, 8'h01,
                 8'h10,
                 8'h00, 8'h03, 8'hAA, 8'hBB, 8'h01, 8'h02, 8'hFF, 8'h00, 8'h67,
                 8'h00, 8'h01, 8'h12, 8'h34, 8'h46};
      //          off n   gaps done err writes
      vecs[0] = '{0,  13, 1'b0, 1'b1, 1'b0, 5};
      vecs[1] = '{13, 13, 1'b0, 1'b0, 1'b1, 5};
      vecs[2] = '{26, 3,  1'b0, 1'b1, 1'b0, 0};
      vecs[3] = '{29, 3,  1'b0, 1'b0, 1'b1, 0};
      vecs[4] = '{32, 1,  1'b0, 1'b0, 1'b1, 0};
      vecs[5] = '{33, 9,  1'b1, 1'b1, 1'b0, 3};
      vecs[6] = '{42, 5,  1'b0, 1'b1, 1'b0, 1};

      repeat (2) @(negedge clk);
      chk("rst_cpu_pause", {31'd0, cpu_pause}, 32'd1);
      chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd0);
      chk("rst_write_en", {31'd0, instr_write_en}, 32'd0);
      chk("rst_addr", {20'd0, instr_writeaddr}, 32'd0);
      chk("rst_data", {16'd0, instr_writedata}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_error", {31'd0, error}, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

      for (int v = 0; v < 7; v++) begin
         pulse_reload();
         chk("reload_pause", {31'd0, cpu_pause}, 32'd1);
         chk("reload_done", {31'd0, done}, 32'd0);
         chk("reload_error", {31'd0, error}, 32'd0);
         chk("reload_addr", {20'd0, instr_writeaddr}, 32'd0);
         rst_pulses = 0;
         strobes    = 0;
         for (int j = 0; j < vecs[v].n; j++) begin
            if (j >= 3 && j < 3 + 2 * vecs[v].exp_writes && ((j - 3) % 2) == 0)
               sb.push_back({12'((j - 3) / 2), stream[vecs[v].off + j - 1], stream[vecs[v].off + j]});
            send_byte(stream[vecs[v].off + j], vecs[v].gaps);
            if (j == vecs[v].n - 1) begin
               chk("last_byte_cpu_reset", {31'd0, cpu_reset}, {31'd0, vecs[v].exp_done});
               chk("last_byte_error", {31'd0, error}, {31'd0, vecs[v].exp_err});
               chk("last_byte_done_not_yet", {31'd0, done}, 32'd0);
            end
         end
         repeat (3) @(negedge clk);
         chk("end_done", {31'd0, done}, {31'd0, vecs[v].exp_done});
         chk("end_error", {31'd0, error}, {31'd0, vecs[v].exp_err});
         chk("end_cpu_pause", {31'd0, cpu_pause}, {31'd0, !vecs[v].exp_done});
         chk("end_cpu_reset", {31'd0, cpu_reset}, 32'd0);
         chk("end_in_ready", {31'd0, in_ready}, 32'd0);
         chk("end_sb_empty", sb.size(), 32'd0);
         chk("end_rst_pulses", rst_pulses, {31'd0, vecs[v].exp_done});
         chk("end_strobes", strobes, vecs[v].exp_writes);
         sb.delete();
      end

      // Mid-frame: reload is ignored, then an async reset aborts the frame.
      pulse_reload();
      sb.push_back({12'd0, 8'hAA, 8'hBB});
      send_byte(8'h00, 1'b0);
      send_byte(8'h03, 1'b0);
      send_byte(8'hAA, 1'b0);
      send_byte(8'hBB, 1'b0);
      pulse_reload();
      chk("midframe_reload_ignored_addr", {20'd0, instr_writeaddr}, 32'd1);
      chk("midframe_reload_in_ready", {31'd0, in_ready}, 32'd1);
      send_byte(8'h01, 1'b0);
      reset = 1'b1;
      #1;
      chk("abort_cpu_pause", {31'd0, cpu_pause}, 32'd1);
      chk("abort_write_en", {31'd0, instr_write_en}, 32'd0);
      chk("abort_addr", {20'd0, instr_writeaddr}, 32'd0);
      chk("abort_data", {16'd0, instr_writedata}, 32'd0);
      chk("abort_done_error", {30'd0, done, error}, 32'd0);
      chk("abort_sb_empty", sb.size(), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      rst_pulses = 0;
      strobes    = 0;
      sb.push_back({12'd0, 8'h12, 8'h34});
      for (int j = 0; j < 5; j++) send_byte(stream[42 + j], 1'b0);
      repeat (3) @(negedge clk);
      chk("fresh_done", {31'd0, done}, 32'd1);
      chk("fresh_strobes", strobes, 32'd1);
      chk("fresh_rst_pulses", rst_pulses, 32'd1);
      chk("fresh_sb_empty", sb.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
